// File: rtl/lab_regional_signal_selector_pkg.sv
// Shared constants and types for the LAB regional signal selector.
// Field widths, FSM encoding and the unconnected select value.
package lab_regional_signal_selector_pkg;

  localparam int DEF_NUM_PIA = 68;
  localparam int DEF_NUM_REG = 36;
  localparam int DEF_SEL_W   = 7;

  localparam logic [DEF_SEL_W-1:0] UNCONNECTED = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/lab_regional_signal_selector_if.sv
// Serial configuration port of the regional signal selector.
// master drives the bit stream, slave is the selector.
interface lab_regional_signal_selector_if;

  logic cfg_start;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;
  logic config_done;
  logic config_busy;

  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, config_done, config_busy
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, config_done, config_busy
  );

endinterface

// File: rtl/lab_regional_signal_selector_mux.sv
// One select field picks one PIA line; out-of-range selects give 0.
// Purely combinational, the parent owns the output register.
module regional_signal_mux #(
  parameter int num_pia_signals = 68,
  parameter int sel_width       = 7
) (
  input  logic [num_pia_signals-1:0] pia,
  input  logic [sel_width-1:0]       sel,
  output logic                       y
);

  localparam logic [sel_width-1:0] LIMIT =
    sel_width'(num_pia_signals);

  always_comb begin
    y = 1'b0;
    if (sel < LIMIT) y = pia[sel];
  end

endmodule

// File: rtl/lab_regional_signal_selector.sv
// LAB-side PIA receiver: serial-loaded shadow selects, atomic commit,
// registered regional bus.
module lab_regional_signal_selector
  import lab_regional_signal_selector_pkg::*;
#(
  parameter int num_pia_signals      = DEF_NUM_PIA,
  parameter int num_regional_signals = DEF_NUM_REG,
  parameter int sel_width            = DEF_SEL_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [num_pia_signals-1:0]      pia_signals,
  lab_regional_signal_selector_if.slave   cfg,
  output logic [num_regional_signals-1:0] regional_signals
);

  localparam int CFG_BITS = num_regional_signals * sel_width;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CFG_BITS-1:0]            shadow_q, shadow_d;
  logic [CFG_BITS-1:0]            active_q, active_d;
  logic                           done_q, done_d;
  logic [num_regional_signals-1:0] reg_q, reg_d;
  logic [CFG_BITS-1:0]            sel_src;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg.cfg_start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cfg.cfg_start) begin
          cnt_d = '0;
        end else if (cfg.cfg_valid) begin
          shadow_d = {cfg.cfg_data, shadow_q[CFG_BITS-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CFG_BITS - 1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        active_d = shadow_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Route from the shadow during COMMIT so the new selects land with config_done.
  assign sel_src = (state_q == COMMIT) ? shadow_q : active_q;

  for (genvar k = 0; k < num_regional_signals; k++) begin : g_mux
    regional_signal_mux #(
      .num_pia_signals (num_pia_signals),
      .sel_width       (sel_width)
    ) u_mux (
      .pia (pia_signals),
      .sel (sel_src[k*sel_width +: sel_width]),
      .y   (reg_d[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '1;
      active_q <= '1;
      done_q   <= 1'b0;
      reg_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
      reg_q    <= reg_d;
    end
  end

  assign cfg.cfg_ready   = (state_q == SHIFT);
  assign cfg.config_busy = (state_q != IDLE);
  assign cfg.config_done = done_q;
  assign regional_signals = reg_q;

endmodule

// File: tb/tb_lab_regional_signal_selector.sv
// Randomized bench for the regional signal selector against a
// field-list routing model.
module tb_lab_regional_signal_selector;

  localparam int NP = 68;
  localparam int NR = 36;
  localparam int SW = 7;
  localparam int NB = NR * SW;

  typedef int fields_t [NR];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] pia = '0;
  logic [NR-1:0] rs;

  lab_regional_signal_selector_if cfg_if ();

  lab_regional_signal_selector dut (
    .clock            (clk),
    .reset            (rst),
    .pia_signals      (pia),
    .cfg              (cfg_if.slave),
    .regional_signals (rs)
  );

  always #5 clk = ~clk;

  int      nvec = 0;
  int      nerr = 0;
  fields_t act;
  fields_t pend;
  bit      commit_pending = 1'b0;

  task automatic check(input string tag,
                       input logic [NP-1:0] got,
                       input logic [NP-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [NR-1:0] route(input fields_t f,
                                          input logic [NP-1:0] p);
    logic [NR-1:0] r;
    r = '0;
    for (int k = 0; k < NR; k++)
      if (f[k] < NP) r[k] = p[f[k]];
    return r;
  endfunction

  task automatic rnd_pia(output logic [NP-1:0] p);
    p = {4'($urandom), $urandom, $urandom};
  endtask

  task automatic rnd_fields(output fields_t f);
    for (int k = 0; k < NR; k++) f[k] = $urandom_range(0, 127);
  endtask

  task automatic unconnected(output fields_t f);
    for (int k = 0; k < NR; k++) f[k] = 127;
  endtask

  // One clock; regional output is checked against the model every cycle.
  task automatic step(input bit chg_pia);
    logic [NP-1:0] p;
    @(posedge clk);
    #1;
    if (commit_pending) begin
      act = pend;
      commit_pending = 1'b0;
    end
    check("regional", rs, route(act, pia));
    if (chg_pia) begin
      rnd_pia(p);
      pia = p;
    end
  endtask

  // mode 0: valid always, 1: toggling, 2: random
  task automatic load(input fields_t f, input int mode,
                      input int stop_at, input bit chg_pia);
    logic [NB-1:0] s;
    int  n;
    int  cyc;
    bit  v;
    bit  tog;
    for (int k = 0; k < NR; k++) s[k*SW +: SW] = SW'(f[k]);
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 1'($urandom);
    step(chg_pia);
    cfg_if.cfg_start = 1'b0;
    check("ready_shift", cfg_if.cfg_ready, 1'b1);
    check("busy_shift", cfg_if.config_busy, 1'b1);
    n   = 0;
    cyc = 0;
    tog = 1'b1;
    while (n < stop_at && cyc < 2000) begin
      v   = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom);
      tog = ~tog;
      cfg_if.cfg_valid = v;
      cfg_if.cfg_data  = s[n];
      step(chg_pia);
      if (v) n++;
      cyc++;
    end
    cfg_if.cfg_valid = 1'b0;
    if (cyc >= 2000) check("load_timeout", 1'b1, 1'b0);
    if (n == NB) begin
      check("busy_commit", cfg_if.config_busy, 1'b1);
      check("ready_commit", cfg_if.cfg_ready, 1'b0);
      check("done_early", cfg_if.config_done, 1'b0);
      pend = f;
      commit_pending = 1'b1;
      step(chg_pia);
      check("done_pulse", cfg_if.config_done, 1'b1);
      check("busy_idle", cfg_if.config_busy, 1'b0);
      step(chg_pia);
      check("done_clear", cfg_if.config_done, 1'b0);
    end
  endtask

  initial begin
    fields_t f;
    logic [NP-1:0] p;
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    unconnected(act);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pia = 68'hF_FFFF_FFFF_FFFF_FFFF;
    step(1'b0);
    check("t1_regional", rs, '0);
    check("t1_ready", cfg_if.cfg_ready, 1'b0);
    check("t1_busy", cfg_if.config_busy, 1'b0);
    check("t1_done", cfg_if.config_done, 1'b0);

    for (int k = 0; k < NR; k++) f[k] = k;
    p = '0;
    p[5] = 1'b1;
    pia = p;
    load(f, 0, NB, 1'b0);
    check("t2_regional", rs, 36'h20);

    pia = '0;
    load(f, 1, NB, 1'b1);
    pia = p;
    step(1'b0);
    step(1'b0);
    check("t3_regional", rs, 36'h20);

    load(f, 2, 100, 1'b1);
    for (int k = 0; k < NR; k++) f[k] = 67;
    p = '0;
    p[67] = 1'b1;
    pia = p;
    load(f, 0, NB, 1'b0);
    check("t4_regional", rs, 36'hF_FFFF_FFFF);

    rnd_fields(f);
    f[0] = 100;
    f[1] = 127;
    f[2] = 68;
    f[3] = 67;
    pia = 68'hF_FFFF_FFFF_FFFF_FFFF;
    load(f, 2, NB, 1'b0);
    check("t5_low4", rs[3:0], 4'b1000);

    rnd_fields(f);
    load(f, 2, 130, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    unconnected(act);
    check("t6_regional", rs, '0);
    check("t6_busy", cfg_if.config_busy, 1'b0);
    check("t6_ready", cfg_if.cfg_ready, 1'b0);
    step(1'b1);
    rnd_fields(f);
    load(f, 0, NB, 1'b1);

    for (int r = 0; r < 4; r++) begin
      rnd_fields(f);
      if (r == 2) load(f, 2, 1 + $urandom_range(0, 250), 1'b1);
      rnd_fields(f);
      load(f, 2, NB, 1'b1);
      for (int c = 0; c < 5; c++) step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
